// File: rtl/mcm_fill_responder_if.sv
// rtl/mcm_fill_responder_if.sv - request/response bundle between cache fill ports and mcm_fill_responder
interface mcm_fill_responder_if;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic [15:0] d_addr;
   logic        d_wr;
   logic [15:0] d_wdata;
   logic        i_grant;
   logic        d_grant;
   logic        d_wr_ack;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic [15:0] rdata_addr;
   logic        rdata_dst;
   logic        busy;

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wr, d_wdata,
      input  i_grant, d_grant, d_wr_ack, rdata, rdata_valid, rdata_addr, rdata_dst, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata,
      output i_grant, d_grant, d_wr_ack, rdata, rdata_valid, rdata_addr, rdata_dst, busy
   );
endinterface

// File: rtl/mcm_fill_responder.sv
// rtl/mcm_fill_responder.sv - arbitrated critical-word-first block-fill responder with pipelined read latency
// Define MCM_DPORT_EN to enable the DCACHE fill/write port; otherwise only ICACHE fills are served.
module mcm_fill_responder #(
   parameter int ADDR_W  = 15,
   parameter int LATENCY = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   mcm_fill_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t state, state_nxt;

   logic [15:0] mem [0:(1<<ADDR_W)-1];

   logic [2:0]  beat;
   logic [11:0] blk_base;
   logic [2:0]  start_word;
   logic        blk_dst;

   logic [LATENCY-1:0] pipe_vld;
   logic [LATENCY-1:0] pipe_dst;
   logic [15:0]        pipe_data [LATENCY];
   logic [15:0]        pipe_addr [LATENCY];

   logic        i_win;
   logic        d_fill_win;
   logic        d_wr_win;
   logic        accept_fill;
   logic        wr_en;
   logic [15:0] fill_addr;
   logic [2:0]  word_idx;
   logic [14:0] rd_word;

   logic        i_grant_q;
   logic        d_grant_q;
   logic        d_wr_ack_q;
   logic        rdata_valid_q;
   logic        rdata_dst_q;
   logic [15:0] rdata_q;
   logic [15:0] rdata_addr_q;

   always_comb begin
      i_win = bus.i_req;
`ifdef MCM_DPORT_EN
      d_fill_win = bus.d_req & ~bus.d_wr & ~bus.i_req;
      d_wr_win   = bus.d_req &  bus.d_wr & ~bus.i_req;
      fill_addr  = bus.i_req ? bus.i_addr : bus.d_addr;
`else
      d_fill_win = 1'b0;
      d_wr_win   = 1'b0;
      fill_addr  = bus.i_addr;
`endif
   end

   always_comb begin
      state_nxt   = state;
      accept_fill = 1'b0;
      wr_en       = 1'b0;
      case (state)
         IDLE: begin
            if (i_win || d_fill_win) begin
               accept_fill = 1'b1;
               state_nxt   = ISSUE;
            end else if (d_wr_win) begin
               wr_en = 1'b1;
            end
         end
         ISSUE: begin
            if (beat == 3'd7) state_nxt = DRAIN;
         end
         DRAIN: begin
            // A waiting fill is taken on the exit edge so back-to-back fills cost LATENCY+9 cycles;
            // a waiting write only commits once the FSM has actually returned to IDLE.
            if (pipe_vld == '0) begin
               if (i_win || d_fill_win) begin
                  accept_fill = 1'b1;
                  state_nxt   = ISSUE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign word_idx = start_word + beat;
   assign rd_word  = {blk_base, word_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat          <= '0;
         blk_base      <= '0;
         start_word    <= '0;
         blk_dst       <= 1'b0;
         pipe_vld      <= '0;
         pipe_dst      <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            pipe_data[s] <= '0;
            pipe_addr[s] <= '0;
         end
         i_grant_q     <= 1'b0;
         d_grant_q     <= 1'b0;
         d_wr_ack_q    <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_dst_q   <= 1'b0;
         rdata_q       <= '0;
         rdata_addr_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept_fill) begin
            beat       <= '0;
            blk_base   <= fill_addr[15:4];
            start_word <= fill_addr[3:1];
            blk_dst    <= d_fill_win;
         end else if (state == ISSUE) begin
            beat <= beat + 3'd1;
         end

         // Stage 0 captures the array word for the beat issued this cycle.
         pipe_vld[0]  <= (state == ISSUE);
         pipe_dst[0]  <= blk_dst;
         pipe_data[0] <= mem[rd_word[ADDR_W-1:0]];
         pipe_addr[0] <= {rd_word, 1'b0};
         for (int s = 1; s < LATENCY; s++) begin
            pipe_vld[s]  <= pipe_vld[s-1];
            pipe_dst[s]  <= pipe_dst[s-1];
            pipe_data[s] <= pipe_data[s-1];
            pipe_addr[s] <= pipe_addr[s-1];
         end

         rdata_valid_q <= pipe_vld[LATENCY-1];
         rdata_q       <= pipe_vld[LATENCY-1] ? pipe_data[LATENCY-1] : 16'h0000;
         rdata_addr_q  <= pipe_vld[LATENCY-1] ? pipe_addr[LATENCY-1] : 16'h0000;
         rdata_dst_q   <= pipe_vld[LATENCY-1] & pipe_dst[LATENCY-1];

         i_grant_q  <= accept_fill & i_win;
         d_grant_q  <= accept_fill & d_fill_win;
         d_wr_ack_q <= wr_en;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[bus.d_addr[ADDR_W:1]] <= bus.d_wdata;
   end

   assign bus.i_grant     = i_grant_q;
   assign bus.d_grant     = d_grant_q;
   assign bus.d_wr_ack    = d_wr_ack_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.rdata_addr  = rdata_addr_q;
   assign bus.rdata_dst   = rdata_dst_q;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mcm_fill_responder.sv
// tb/tb_mcm_fill_responder.sv - self-checking bench for mcm_fill_responder
`timescale 1ns/1ps
module tb_mcm_fill_responder;
   localparam int LAT = 4;
   localparam int AW  = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mcm_fill_responder_if bus();

   mcm_fill_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] model_mem [0:(1<<AW)-1];
   logic [15:0] got_data [8];
   logic [15:0] got_addr [8];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] beat0;
      logic [15:0] beat7;
      logic [15:0] addr7;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=response cyc=%0d", name, cyc);
   endtask

   // Reference: beat k of a fill returns word ((start + k) mod 8) of the aligned 16-byte block.
   function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
      logic [2:0] w;
      w = 3'(int'(a[3:1]) + k);
      return {a[15:4], w, 1'b0};
   endfunction

   function automatic logic [15:0] exp_data(input logic [15:0] a, input int k);
      logic [15:0] ea;
      ea = exp_addr(a, k);
      return model_mem[ea[15:1]];
   endfunction

   task automatic clr_inputs();
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_addr  = '0;
      bus.d_wr    = 1'b0;
      bus.d_wdata = '0;
   endtask

   task automatic request_fill(input logic is_d, input logic [15:0] a, output int c0);
      c0 = -1;
      if (is_d) begin
         bus.d_req  = 1'b1;
         bus.d_wr   = 1'b0;
         bus.d_addr = a;
      end else begin
         bus.i_req  = 1'b1;
         bus.i_addr = a;
      end
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if ((is_d ? bus.d_grant : bus.i_grant) === 1'b1) begin
            c0 = cyc;
            break;
         end
      end
      if (is_d) bus.d_req = 1'b0;
      else      bus.i_req = 1'b0;
      if (c0 < 0) timeout("grant");
   endtask

   // Called at the negedge where the grant was seen; checks every cycle up to the IDLE return.
   task automatic collect(input logic [15:0] a, input logic dst, input bit follow_d);
      int k;
      for (int r = 1; r <= LAT + 9; r++) begin
         @(negedge clk);
         k = r - (1 + LAT);
         if (k >= 0 && k < 8) begin
            got_data[k] = bus.rdata;
            got_addr[k] = bus.rdata_addr;
            chk("beat_valid", bus.rdata_valid, 1);
            chk("beat_data", bus.rdata, exp_data(a, k));
            chk("beat_addr", bus.rdata_addr, exp_addr(a, k));
            chk("beat_dst", bus.rdata_dst, dst);
         end else begin
            chk("no_beat_valid", bus.rdata_valid, 0);
            chk("no_beat_rdata", bus.rdata, 0);
         end
         chk("busy", bus.busy, (r < LAT + 9) || follow_d);
         chk("i_grant_quiet", bus.i_grant, 0);
         chk("d_grant", bus.d_grant, (r == LAT + 9) && follow_d);
         chk("d_wr_ack_quiet", bus.d_wr_ack, 0);
      end
   endtask

   task automatic do_fill(input logic is_d, input logic [15:0] a);
      int c0;
      request_fill(is_d, a, c0);
      if (c0 >= 0) collect(a, is_d, 1'b0);
   endtask

`ifdef MCM_DPORT_EN
   task automatic do_write(input logic [15:0] a, input logic [15:0] wd);
      int c0;
      int s;
      c0 = -1;
      s  = cyc;
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (bus.d_wr_ack === 1'b1) begin
            c0 = cyc;
            break;
         end
      end
      bus.d_req = 1'b0;
      bus.d_wr  = 1'b0;
      if (c0 < 0) timeout("wr_ack");
      else begin
         chk("wr_ack_latency", c0 - s, 1);
         model_mem[a[15:1]] = wd;
      end
      @(negedge clk);
      chk("wr_ack_pulse", bus.d_wr_ack, 0);
      chk("wr_busy", bus.busy, 0);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int cf;
      logic [15:0] a;
      logic [15:0] v;

      vecs[0] = '{16'h0046, 16'hA003, 16'hA002, 16'h0044};
      vecs[1] = '{16'h0040, 16'hA000, 16'hA007, 16'h004E};
      vecs[2] = '{16'h004F, 16'hA007, 16'hA006, 16'h004C};
      vecs[3] = '{16'h0082, 16'hB001, 16'hB000, 16'h0080};
      vecs[4] = '{16'h008E, 16'hB007, 16'hB006, 16'h008C};

      clr_inputs();
      for (int w = 0; w < (1 << AW); w++) begin
         v = 16'(w * 7 + 16'h1357);
         if (w >= 16'h20 && w < 16'h28) v = 16'(16'hA000 + (w - 16'h20));
         if (w >= 16'h40 && w < 16'h48) v = 16'(16'hB000 + (w - 16'h40));
         model_mem[w] = v;
         dut.mem[w]   = v;
      end

      repeat (3) @(negedge clk);
      chk("rst_rdata_valid", bus.rdata_valid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rdata_addr", bus.rdata_addr, 0);
      chk("rst_rdata_dst", bus.rdata_dst, 0);
      chk("rst_i_grant", bus.i_grant, 0);
      chk("rst_d_grant", bus.d_grant, 0);
      chk("rst_d_wr_ack", bus.d_wr_ack, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         do_fill(1'b0, vecs[i].addr);
         chk("vec_beat0", got_data[0], vecs[i].beat0);
         chk("vec_beat7", got_data[7], vecs[i].beat7);
         chk("vec_addr0", got_addr[0], {vecs[i].addr[15:1], 1'b0});
         chk("vec_addr7", got_addr[7], vecs[i].addr7);
      end

`ifdef MCM_DPORT_EN
      // Simultaneous requests: ICACHE first, DCACHE granted exactly LAT+9 cycles later.
      bus.d_req  = 1'b1;
      bus.d_wr   = 1'b0;
      bus.d_addr = 16'h0200;
      request_fill(1'b0, 16'h0100, cf);
      if (cf >= 0) begin
         collect(16'h0100, 1'b0, 1'b1);
         bus.d_req = 1'b0;
         collect(16'h0200, 1'b1, 1'b0);
      end
      clr_inputs();

      do_write(16'h0010, 16'hBEEF);
      do_fill(1'b0, 16'h0010);
      chk("wr_then_read", got_data[0], 16'hBEEF);

      // Write held during a fill: acked only after the FSM has returned to IDLE.
      request_fill(1'b0, 16'h0100, cf);
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h0102;
      bus.d_wdata = 16'h5A5A;
      if (cf >= 0) begin
         collect(16'h0100, 1'b0, 1'b0);
         @(negedge clk);
         chk("stalled_wr_ack", bus.d_wr_ack, 1);
      end
      clr_inputs();
      model_mem[16'h0102 >> 1] = 16'h5A5A;
      @(negedge clk);
      do_fill(1'b1, 16'h0102);
      chk("stalled_wr_data", got_data[0], 16'h5A5A);
`else
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h0040;
      bus.d_wdata = 16'hFFFF;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         chk("nodport_wr_ack", bus.d_wr_ack, 0);
         chk("nodport_d_grant", bus.d_grant, 0);
         chk("nodport_busy", bus.busy, 0);
      end
      bus.d_wr = 1'b0;
      repeat (5) @(negedge clk);
      chk("nodport_fill_busy", bus.busy, 0);
      clr_inputs();
      do_fill(1'b0, 16'h0040);
      chk("nodport_array_kept", got_data[0], 16'hA000);
`endif

      // Reset in the middle of a burst, right after beat 2 is seen.
      request_fill(1'b0, 16'h0046, c0);
      if (c0 >= 0) begin
         repeat (LAT + 3) @(negedge clk);
         chk("pre_reset_beat2", bus.rdata, 16'hA005);
         rst_n = 1'b0;
         #1;
         chk("mid_rst_valid", bus.rdata_valid, 0);
         chk("mid_rst_rdata", bus.rdata, 0);
         chk("mid_rst_addr", bus.rdata_addr, 0);
         chk("mid_rst_busy", bus.busy, 0);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("post_rst_no_beat", bus.rdata_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
         end
      end
      do_fill(1'b0, 16'h0086);

      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a = 16'(16'h0300 + $urandom_range(0, 127));
`ifdef MCM_DPORT_EN
         case ($urandom_range(0, 2))
            0: do_fill(1'b0, a);
            1: do_fill(1'b1, a);
            default: do_write(a, 16'($urandom));
         endcase
`else
         bus.d_req   = 1'($urandom_range(0, 1));
         bus.d_wr    = 1'($urandom_range(0, 1));
         bus.d_addr  = a;
         bus.d_wdata = 16'($urandom);
         do_fill(1'b0, a);
`endif
         clr_inputs();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
